// File: rtl/panel_bus_capture.sv
// Captures 8080 bus activity into frame-stable front-panel LED words.
// Optional `PANEL_STICKY_STATUS_EN: status LEDs show the OR of every status word latched in the frame.
module panel_bus_capture #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic [7:0]  cpu_din,
  input  logic        cpu_sync,
  input  logic        cpu_dbin,
  input  logic        cpu_wr_n,
  input  logic        cpu_inte,
  input  logic        cpu_prot,
  input  logic        cpu_wait,
  input  logic        cpu_hlda,
  input  logic        frame_tick,
  output logic [15:0] addrLEDs,
  output logic [7:0]  dataLEDs,
  output logic [7:0]  statusLEDs,
  output logic [3:0]  otherLEDs
);

  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);

  typedef enum logic {IDLE, XFER} state_t;

  state_t           state;
  logic [TO_W-1:0]  to_cnt;
  logic             sync_q;
  logic             sync_rise;
  logic [15:0]      addr_cur;
  logic [7:0]       stat_cur;
  logic [7:0]       data_cur;
  logic             wait_acc;
  logic             hlda_acc;

  assign sync_rise = cpu_sync & ~sync_q;

  // SYNC edge detect and address/status latches
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q   <= 1'b0;
      addr_cur <= '0;
      stat_cur <= '0;
    end else begin
      sync_q <= cpu_sync;
      if (sync_rise) begin
        addr_cur <= cpu_addr;
        stat_cur <= cpu_dout;
      end
    end
  end

  // Transfer tracker: a new SYNC edge restarts the cycle ahead of any strobe
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      to_cnt   <= '0;
      data_cur <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sync_rise) begin
            state  <= XFER;
            to_cnt <= '0;
          end
        end
        XFER: begin
          if (sync_rise) begin
            to_cnt <= '0;
          end else if (cpu_dbin) begin
            data_cur <= cpu_din;
            state    <= IDLE;
          end else if (!cpu_wr_n) begin
            data_cur <= cpu_dout;
            state    <= IDLE;
          end else if (to_cnt == TO_MAX) begin
            state <= IDLE;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Frame accumulators reload with the tick-cycle input so no event is dropped
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_acc <= 1'b0;
      hlda_acc <= 1'b0;
    end else begin
      wait_acc <= frame_tick ? cpu_wait : (wait_acc | cpu_wait);
      hlda_acc <= frame_tick ? cpu_hlda : (hlda_acc | cpu_hlda);
    end
  end

`ifdef PANEL_STICKY_STATUS_EN
  logic [7:0] stat_acc;
  logic [7:0] stat_new;

  assign stat_new = sync_rise ? cpu_dout : 8'h00;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_acc <= '0;
    end else begin
      stat_acc <= frame_tick ? stat_new : (stat_acc | stat_new);
    end
  end
`endif

  // Snapshot on frame tick; uses pre-update latch values
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addrLEDs   <= '0;
      dataLEDs   <= '0;
      statusLEDs <= '0;
      otherLEDs  <= '0;
    end else if (frame_tick) begin
      addrLEDs <= addr_cur;
      dataLEDs <= data_cur;
`ifdef PANEL_STICKY_STATUS_EN
      statusLEDs <= stat_acc | stat_new;
`else
      statusLEDs <= stat_cur;
`endif
      otherLEDs <= {hlda_acc | cpu_hlda, wait_acc | cpu_wait, cpu_prot, cpu_inte};
    end
  end

endmodule

// File: tb/tb_panel_bus_capture.sv
// Scoreboard bench for panel_bus_capture: ticks push expected panel words, a monitor checks them.
module tb_panel_bus_capture;

`ifdef PANEL_STICKY_STATUS_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif
  localparam int unsigned TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_dout = '0;
  logic [7:0]  cpu_din = '0;
  logic        cpu_sync = 1'b0;
  logic        cpu_dbin = 1'b0;
  logic        cpu_wr_n = 1'b1;
  logic        cpu_inte = 1'b0;
  logic        cpu_prot = 1'b0;
  logic        cpu_wait = 1'b0;
  logic        cpu_hlda = 1'b0;
  logic        frame_tick = 1'b0;
  logic [15:0] addrLEDs;
  logic [7:0]  dataLEDs;
  logic [7:0]  statusLEDs;
  logic [3:0]  otherLEDs;

  int checks = 0;
  int failures = 0;
  logic [35:0] exp_q[$];

  panel_bus_capture #(.TIMEOUT(TIMEOUT), .TO_W(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_din(cpu_din),
    .cpu_sync(cpu_sync), .cpu_dbin(cpu_dbin), .cpu_wr_n(cpu_wr_n),
    .cpu_inte(cpu_inte), .cpu_prot(cpu_prot), .cpu_wait(cpu_wait), .cpu_hlda(cpu_hlda),
    .frame_tick(frame_tick),
    .addrLEDs(addrLEDs), .dataLEDs(dataLEDs), .statusLEDs(statusLEDs), .otherLEDs(otherLEDs)
  );

  always #5 clk = ~clk;

  function automatic logic [35:0] mk(input logic [15:0] a, input logic [7:0] d,
                                     input logic [7:0] s, input logic [3:0] o);
    return {a, d, s, o};
  endfunction

  function automatic logic [7:0] st(input logic [7:0] sticky_v, input logic [7:0] plain_v);
    return STICKY ? sticky_v : plain_v;
  endfunction

  task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got addr=%h data=%h stat=%h other=%h, want addr=%h data=%h stat=%h other=%h",
               nm, act[35:20], act[19:12], act[11:4], act[3:0],
               exp[35:20], exp[19:12], exp[11:4], exp[3:0]);
    end
  endtask

  // Monitor: after a tick edge pop and compare; otherwise outputs must hold
  initial begin
    logic [35:0] last;
    logic        t;
    last = '0;
    forever begin
      @(posedge clk);
      t = frame_tick;
      #1;
      if (!reset_n) begin
        last = '0;
      end else if (t) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL tick_without_expectation");
        end else begin
          last = exp_q.pop_front();
          chk("tick_snapshot", {addrLEDs, dataLEDs, statusLEDs, otherLEDs}, last);
        end
      end else begin
        chk("hold_between_ticks", {addrLEDs, dataLEDs, statusLEDs, otherLEDs}, last);
      end
    end
  end

  task automatic bus_cycle(input logic [15:0] a, input logic [7:0] s, input bit rd,
                           input logic [7:0] d, input int gap);
    @(negedge clk);
    cpu_sync = 1'b1; cpu_addr = a; cpu_dout = s;
    @(negedge clk);
    cpu_sync = 1'b0;
    repeat (gap) @(negedge clk);
    if (rd) begin cpu_dbin = 1'b1; cpu_din = d; end
    else begin cpu_wr_n = 1'b0; cpu_dout = d; end
    @(negedge clk);
    cpu_dbin = 1'b0; cpu_wr_n = 1'b1;
  endtask

  task automatic tick(input logic [35:0] e);
    exp_q.push_back(e);
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_values", {addrLEDs, dataLEDs, statusLEDs, otherLEDs}, '0);
    reset_n = 1'b1;
    tick(mk(16'h0000, 8'h00, 8'h00, 4'h0));

    // Read cycle, strobe three cycles after SYNC
    bus_cycle(16'h1234, 8'hA2, 1'b1, 8'h3E, 2);
    tick(mk(16'h1234, 8'h3E, 8'hA2, 4'h0));

    // Write cycle
    cpu_inte = 1'b1;
    bus_cycle(16'h4000, 8'h10, 1'b0, 8'h55, 2);
    tick(mk(16'h4000, 8'h55, 8'h10, 4'h1));

    // Timeout: strobe arrives after XFER has given up and must be ignored
    bus_cycle(16'h5000, 8'h42, 1'b1, 8'hFF, TIMEOUT + 5);
    tick(mk(16'h5000, 8'h55, 8'h42, 4'h1));

    // Late strobe just inside the timeout window is still accepted
    bus_cycle(16'h6000, 8'h81, 1'b1, 8'h77, TIMEOUT - 1);
    tick(mk(16'h6000, 8'h77, 8'h81, 4'h1));

    // Long SYNC: bus changes while SYNC stays high must not re-latch
    @(negedge clk);
    cpu_sync = 1'b1; cpu_addr = 16'h7000; cpu_dout = 8'h0A;
    @(negedge clk);
    cpu_addr = 16'h7FFF; cpu_dout = 8'h01;
    repeat (4) @(negedge clk);
    cpu_sync = 1'b0;
    @(negedge clk);
    cpu_wr_n = 1'b0; cpu_dout = 8'h99;
    @(negedge clk);
    cpu_wr_n = 1'b1;
    tick(mk(16'h7000, 8'h99, 8'h0A, 4'h1));

    // Tick and SYNC edge in the same cycle
    exp_q.push_back(mk(16'h7000, 8'h99, st(8'h20, 8'h0A), 4'h1));
    @(negedge clk);
    frame_tick = 1'b1; cpu_sync = 1'b1; cpu_addr = 16'hBEEF; cpu_dout = 8'h20;
    @(negedge clk);
    frame_tick = 1'b0; cpu_sync = 1'b0;
    repeat (3) @(negedge clk);
    tick(mk(16'hBEEF, 8'h99, 8'h20, 4'h1));

    // Two status words in one frame
    bus_cycle(16'h0100, 8'h04, 1'b1, 8'h11, 1);
    bus_cycle(16'h0200, 8'h80, 1'b1, 8'h22, 1);
    tick(mk(16'h0200, 8'h22, st(8'h84, 8'h80), 4'h1));

    // One-cycle WAIT pulse, then HLDA raised in the tick cycle itself
    @(negedge clk);
    cpu_wait = 1'b1;
    @(negedge clk);
    cpu_wait = 1'b0;
    exp_q.push_back(mk(16'h0200, 8'h22, st(8'h00, 8'h80), 4'hD));
    @(negedge clk);
    frame_tick = 1'b1; cpu_hlda = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0; cpu_hlda = 1'b0;
    tick(mk(16'h0200, 8'h22, st(8'h00, 8'h80), 4'h9));
    cpu_prot = 1'b1;
    tick(mk(16'h0200, 8'h22, st(8'h00, 8'h80), 4'h3));
    cpu_prot = 1'b0; cpu_inte = 1'b0;

    // Reset in the middle of a transfer
    @(negedge clk);
    cpu_sync = 1'b1; cpu_addr = 16'hAAAA; cpu_dout = 8'h33;
    @(negedge clk);
    cpu_sync = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("async_reset_mid_xfer", {addrLEDs, dataLEDs, statusLEDs, otherLEDs}, '0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    cpu_dbin = 1'b1; cpu_din = 8'h5A;
    @(negedge clk);
    cpu_dbin = 1'b0;
    tick(mk(16'h0000, 8'h00, 8'h00, 4'h0));

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL pending_expectations: got %0d left, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
